// File: rtl/fsm_state_monitor.sv
// Passive checker for a 3-bit producer state-code stream: syncs on the idle code,
// flags encoding/transition/stall faults, counts them and locks out until cleared.
module fsm_state_monitor #(
    parameter int unsigned STALL_LIMIT = 8,
    parameter int unsigned MAX_ERRORS  = 3,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state_code,
    input  logic             code_valid,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             in_sync,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_type,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       last_code
);

    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] FT_NONE  = 2'd0;
    localparam logic [1:0] FT_ENC   = 2'd1;
    localparam logic [1:0] FT_TRANS = 2'd2;
    localparam logic [1:0] FT_STALL = 2'd3;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              clr_ack_d, in_sync_d, locked_d, fault_d;
    logic [1:0]        fault_type_d, last_code_d;
    logic [CNT_W-1:0]  err_d;

    logic              clr_go;
    logic [1:0]        code2;
    logic [1:0]        succ_code;
    logic [CNT_W-1:0]  err_inc;
    logic              fault_hit;
    logic [1:0]        fault_kind;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            hold_q     <= '0;
            clr_ack    <= 1'b0;
            in_sync    <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_type <= FT_NONE;
            err_count  <= '0;
            last_code  <= 2'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            clr_ack    <= clr_ack_d;
            in_sync    <= in_sync_d;
            locked     <= locked_d;
            fault      <= fault_d;
            fault_type <= fault_type_d;
            err_count  <= err_d;
            last_code  <= last_code_d;
        end
    end

    // Next-state, sample classification and output update
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        clr_ack_d    = clr_ack;
        fault_d      = 1'b0;
        fault_type_d = fault_type;
        err_d        = err_count;
        last_code_d  = last_code;
        fault_hit    = 1'b0;
        fault_kind   = FT_NONE;

        code2     = state_code[1:0];
        succ_code = last_code + 2'd1;
        err_inc   = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + CNT_W'(1);
        clr_go    = clr_req && !clr_ack;

        if (clr_go) begin
            // A new clear request beats any sample arriving on the same edge
            clr_ack_d    = 1'b1;
            err_d        = '0;
            fault_type_d = FT_NONE;
            hold_d       = '0;
            state_d      = ST_SYNC;
        end else begin
            clr_ack_d = clr_ack && clr_req;
            if (code_valid) begin
                case (state_q)
                    ST_SYNC: begin
                        if (state_code == 3'd0) begin
                            state_d     = ST_TRACK;
                            last_code_d = 2'd0;
                            hold_d      = HOLD_W'(1);
                        end
                    end
                    ST_TRACK: begin
                        if (state_code[2]) begin
                            fault_hit  = 1'b1;
                            fault_kind = FT_ENC;
                        end else if (code2 != last_code && code2 != succ_code && code2 != 2'd0) begin
                            fault_hit  = 1'b1;
                            fault_kind = FT_TRANS;
                        end else if (code2 == last_code && last_code != 2'd0 &&
                                     hold_q == HOLD_W'(STALL_LIMIT)) begin
                            fault_hit  = 1'b1;
                            fault_kind = FT_STALL;
                        end else begin
                            last_code_d = code2;
                            if (code2 == last_code) begin
                                hold_d = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + HOLD_W'(1);
                            end else begin
                                hold_d = HOLD_W'(1);
                            end
                        end

                        if (fault_hit) begin
                            fault_d      = 1'b1;
                            fault_type_d = fault_kind;
                            err_d        = err_inc;
                            state_d      = (err_inc >= CNT_W'(MAX_ERRORS)) ? ST_LOCKED : ST_SYNC;
                        end
                    end
                    ST_LOCKED: begin
                        state_d = ST_LOCKED;
                    end
                    default: begin
                        state_d = ST_SYNC;
                    end
                endcase
            end
        end

        in_sync_d = (state_d == ST_TRACK);
        locked_d  = (state_d == ST_LOCKED);
    end

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed bench for fsm_state_monitor: a spec-level reference model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fsm_state_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int          ERR_SAT = (1 << CNT_W) - 1;
    localparam int          STALL   = 8;
    localparam int          MAXERR  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [2:0]       state_code = 3'd0;
    logic             code_valid = 1'b0;
    logic             clr_req = 1'b0;
    logic             clr_ack;
    logic             in_sync;
    logic             locked;
    logic             fault;
    logic [1:0]       fault_type;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       last_code;

    int total = 0;
    int passed = 0;

    fsm_state_monitor #(
        .STALL_LIMIT(STALL),
        .MAX_ERRORS (MAXERR),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state_code(state_code),
        .code_valid(code_valid),
        .clr_req   (clr_req),
        .clr_ack   (clr_ack),
        .in_sync   (in_sync),
        .locked    (locked),
        .fault     (fault),
        .fault_type(fault_type),
        .err_count (err_count),
        .last_code (last_code)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = waiting for idle, 1 = tracking, 2 = locked out
    int m_mode = 0;
    int m_last = 0;
    int m_hold = 0;
    int m_err  = 0;
    int m_type = 0;
    int m_fault = 0;
    int m_ack  = 0;

    always @(posedge clk or negedge rst_n) begin
        int c;
        int f;
        if (!rst_n) begin
            m_mode = 0; m_last = 0; m_hold = 0; m_err = 0;
            m_type = 0; m_fault = 0; m_ack = 0;
        end else begin
            m_fault = 0;
            c = int'(state_code);
            if (clr_req && m_ack == 0) begin
                m_ack = 1; m_err = 0; m_type = 0; m_hold = 0; m_mode = 0;
            end else begin
                m_ack = (m_ack == 1 && clr_req) ? 1 : 0;
                if (code_valid) begin
                    if (m_mode == 0) begin
                        if (c == 0) begin
                            m_mode = 1; m_last = 0; m_hold = 1;
                        end
                    end else if (m_mode == 1) begin
                        f = 0;
                        if (c > 3) f = 1;
                        else if (c != m_last && c != (m_last + 1) % 4 && c != 0) f = 2;
                        else if (c == m_last && m_last != 0 && m_hold == STALL) f = 3;
                        if (f != 0) begin
                            m_fault = 1;
                            m_type  = f;
                            if (m_err < ERR_SAT) m_err = m_err + 1;
                            m_mode  = (m_err >= MAXERR) ? 2 : 0;
                        end else begin
                            if (c == m_last) m_hold = (m_hold < 255) ? m_hold + 1 : m_hold;
                            else m_hold = 1;
                            m_last = c;
                        end
                    end
                end
            end
        end
    end

    // Whole-output comparison against the model every cycle
    always @(negedge clk) begin
        logic [11:0] act;
        logic [11:0] exp;
        act = {clr_ack, in_sync, locked, fault, fault_type, err_count, last_code};
        exp = {(m_ack == 1), (m_mode == 1), (m_mode == 2), (m_fault == 1),
               2'(m_type), CNT_W'(m_err), 2'(m_last)};
        total++;
        if (act !== exp)
            $display("FAIL model_cmp t=%0t: got ack=%b sync=%b lock=%b flt=%b type=%0d err=%0d last=%0d, expected ack=%b sync=%b lock=%b flt=%b type=%0d err=%0d last=%0d",
                     $time, act[11], act[10], act[9], act[8], act[7:6], act[5:2], act[1:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:6], exp[5:2], exp[1:0]);
        else
            passed++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic cyc(input bit v, input logic [2:0] c, input bit r);
        code_valid = v;
        state_code = c;
        clr_req    = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        chk("reset_in_sync", int'(in_sync), 0);
        chk("reset_err", int'(err_count), 0);
        chk("reset_locked", int'(locked), 0);

        // Legal walk 0,1,2,3,0,0
        cyc(1, 3'd0, 0);
        chk("sync_on_zero", int'(in_sync), 1);
        cyc(1, 3'd1, 0); chk("walk_last1", int'(last_code), 1);
        cyc(1, 3'd2, 0); chk("walk_last2", int'(last_code), 2);
        cyc(1, 3'd3, 0); chk("walk_last3", int'(last_code), 3);
        cyc(1, 3'd0, 0); chk("walk_wrap0", int'(last_code), 0);
        cyc(1, 3'd0, 0); chk("walk_fault", int'(fault), 0);
        chk("walk_err", int'(err_count), 0);

        // Transition fault 1 -> 3
        cyc(1, 3'd1, 0);
        cyc(1, 3'd3, 0);
        chk("trans_fault", int'(fault), 1);
        chk("trans_type", int'(fault_type), 2);
        chk("trans_err", int'(err_count), 1);
        chk("trans_sync", int'(in_sync), 0);
        chk("trans_last_kept", int'(last_code), 1);
        cyc(0, 3'd0, 0);
        chk("fault_one_cycle", int'(fault), 0);
        cyc(1, 3'd2, 0); chk("sync_ignores_2", int'(in_sync), 0);
        cyc(1, 3'd0, 0); chk("resync", int'(in_sync), 1);

        // Encoding fault, then invalid samples have no effect
        cyc(1, 3'd5, 0);
        chk("enc_type", int'(fault_type), 1);
        chk("enc_err", int'(err_count), 2);
        chk("enc_last_kept", int'(last_code), 0);
        cyc(0, 3'd5, 0);
        cyc(0, 3'd3, 0);
        chk("invalid_err", int'(err_count), 2);
        chk("invalid_fault", int'(fault), 0);

        // Third fault locks out
        cyc(1, 3'd0, 0);
        cyc(1, 3'd6, 0);
        chk("lock_on_third", int'(locked), 1);
        chk("lock_err", int'(err_count), 3);
        cyc(1, 3'd0, 0);
        chk("locked_ignores", int'(in_sync), 0);
        chk("still_locked", int'(locked), 1);

        // Clear handshake held for 5 cycles
        cyc(0, 3'd0, 1);
        chk("clr_ack", int'(clr_ack), 1);
        chk("clr_err", int'(err_count), 0);
        chk("clr_unlock", int'(locked), 0);
        chk("clr_type", int'(fault_type), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 3'd0, 1);
            chk("clr_ack_held", int'(clr_ack), 1);
        end
        cyc(0, 3'd0, 0);
        chk("clr_ack_drop", int'(clr_ack), 0);

        // Stall: 0, 1, then eight more 1s
        cyc(1, 3'd0, 0);
        cyc(1, 3'd1, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 3'd1, 0);
            chk("hold_no_fault", int'(fault), 0);
        end
        cyc(1, 3'd1, 0);
        chk("stall_fault", int'(fault), 1);
        chk("stall_type", int'(fault_type), 3);
        chk("stall_err", int'(err_count), 1);

        // Idle may hold indefinitely
        for (int i = 0; i < 20; i++) begin
            cyc(1, 3'd0, 0);
            chk("idle_hold", int'(fault), 0);
        end
        chk("idle_sync", int'(in_sync), 1);

        // Asynchronous reset at last_code=2
        cyc(1, 3'd1, 0);
        cyc(1, 3'd2, 0);
        chk("pre_rst_last", int'(last_code), 2);
        code_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out",
            int'({clr_ack, in_sync, locked, fault, fault_type, err_count, last_code}), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1, 3'd2, 0); chk("post_rst_ignore", int'(in_sync), 0);
        cyc(1, 3'd0, 0); chk("post_rst_sync", int'(in_sync), 1);

        // Clear coincident with an illegal sample
        cyc(1, 3'd3, 0);
        chk("pre_clr_err", int'(err_count), 1);
        cyc(1, 3'd0, 0);
        cyc(1, 3'd7, 1);
        chk("clr_wins_fault", int'(fault), 0);
        chk("clr_wins_ack", int'(clr_ack), 1);
        chk("clr_wins_err", int'(err_count), 0);
        cyc(0, 3'd0, 0);
        chk("clr_wins_drop", int'(clr_ack), 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fsm_state_monitor.md
# fsm_state_monitor

Passive checker that sits on the 3-bit state-code output of the team's control FSMs and consumes the code stream they produce. It synchronises to the producer's idle code, then checks every sampled code for legal encoding, legal transitions and stalls. It reports faults as a one-cycle pulse plus a latched type, and counts them. Once the error budget is exhausted it locks out until software clears it through a req/ack handshake.

## Interface
- STALL_LIMIT, 8: maximum number of consecutive identical non-zero valid samples allowed; range 2..255.
- MAX_ERRORS, 3: number of faults that forces LOCKED; range 1..2^CNT_W-1.
- CNT_W, 4: width of the error counter.

- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- state_code  input  3  code from the producer FSM; legal values 0..3.
- code_valid  input  1  state_code is sampled on an edge only when this is 1.
- clr_req  input  1  level request to clear errors and lockout.
- clr_ack  output  1  clear acknowledge.
- in_sync  output  1  1 while in TRACK.
- locked  output  1  1 while in LOCKED.
- fault  output  1  one-cycle pulse per detected fault.
- fault_type  output  2  last fault: 0 none, 1 encoding, 2 transition, 3 stall.
- err_count  output  CNT_W  faults since reset or last clear; saturates at all-ones.
- last_code  output  2  last legal code accepted in TRACK.

## Operation
- States: SYNC (reset state), TRACK, LOCKED. All outputs are registered. Reset value of every output is 0. hold_cnt resets to 0.
- SYNC: a valid sample with code 0 goes to TRACK, sets last_code=0 and hold_cnt=1. All other samples are ignored and raise no fault.
- TRACK: each valid sample is classified in priority order:
  - Code 4..7: encoding fault, type 1.
  - Code not equal to last_code, not last_code+1 mod 4, and not 0: transition fault, type 2.
  - Code equal to a non-zero last_code with hold_cnt==STALL_LIMIT: stall fault, type 3.
  - Otherwise legal.
- Legal sample: update last_code. hold_cnt increments if the code is unchanged (saturating), otherwise it reloads to 1. Code 0 may hold indefinitely.
- Fault:
  - fault pulses for 1 cycle, fault_type is latched, and err_count increments (saturating).
  - last_code and hold_cnt are unchanged.
  - The next state is LOCKED if the new err_count >= MAX_ERRORS, otherwise SYNC.
- LOCKED: locked=1, in_sync=0, and all samples are ignored. The only exits are a clear or reset.
- Clear handshake:
  - When clr_req=1 and clr_ack=0: err_count=0, fault_type=0, hold_cnt=0, state goes to SYNC, and clr_ack=1 on the next cycle.
  - clr_ack stays high while clr_req stays high. No further clear is performed while it is high.
  - clr_ack drops the cycle after clr_req is seen low.
- A clear in the same cycle as a valid sample wins. The sample is discarded and no fault is raised.
- code_valid=0 means no state change, no counter change, and fault=0.

## Timing
- Latency: a sample on edge N is reflected in fault, fault_type, err_count, last_code, in_sync and locked after edge N, i.e. visible during cycle N+1.
- fault is high for exactly one cycle per faulting sample. Back-to-back faults are impossible because a fault leaves TRACK.
- Asynchronous reset mid-operation forces SYNC and zeroes all outputs and counters immediately. The first valid 0 after deassertion resynchronises.
- Clear latency: clr_req is sampled high on edge N; clr_ack=1, locked=0 and err_count=0 after edge N.

## Test plan
- Reset, then valid codes 0,1,2,3,0,0 → in_sync=1 one cycle after the first 0; last_code follows 0,1,2,3,0,0; fault never asserted; err_count=0.
- In TRACK at last_code=1, send 3 → one-cycle fault, fault_type=2, err_count=1, in_sync=0. Then send 2 → ignored. Then 0 → in_sync=1.
- In TRACK, send 5 → fault_type=1, err_count increments, last_code unchanged. Codes with code_valid=0 produce no effect.
- With STALL_LIMIT=8, send 0, 1, then eight more 1s → fault on the 9th consecutive 1 with fault_type=3. Eight consecutive 1s alone raise no fault; 20 consecutive 0s raise no fault.
- With MAX_ERRORS=3, cause three faults → locked=1 after the third, and further samples are ignored. Raise clr_req → clr_ack=1 next cycle, err_count=0, locked=0, fault_type=0. clr_req held 5 cycles keeps clr_ack high; clr_ack drops one cycle after clr_req falls.
- Pulse rst_n low mid-TRACK at last_code=2 → all outputs 0 immediately. A clear coincident with an illegal sample → no fault, clr_ack=1, err_count=0.
